// File: rtl/alloc_pkg.sv
// Shared definitions for the card-list block allocator.
// Contents: FSM state encoding, header used-bit index helper, the NULL block
// address, and block-index <-> base-address helpers.
// Related build option: ALLOC_NEXT_FIT_EN (consumed by block_allocator).
package alloc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Block 0 doubles as the list terminator, so its base address is NULL.
  localparam int unsigned NULL_ADDR = 0;

  // The used flag lives in the MSB of a block's first (header) word.
  function automatic int unsigned hdr_used_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

  function automatic int unsigned block_base(input int unsigned idx,
                                             input int unsigned block_words);
    return idx * block_words;
  endfunction

  function automatic int unsigned block_index(input int unsigned addr,
                                              input int unsigned block_words);
    return addr / block_words;
  endfunction

endpackage

// File: rtl/alloc_block_ptr.sv
// Block-index scan pointer for the allocator.
// Ports:
//   clock, reset  clock / asynchronous active-high reset (index -> 1, count -> 0)
//   restart       load index 1 (first block after NULL)
//   clear_cnt     zero the checked-candidate count
//   inc           advance index (wrapping NUM_BLOCKS-1 -> 1) and bump the count
//   idx_nxt       index value after this cycle's load/increment (combinational)
//   last          the current candidate is the final one of a full scan
module alloc_block_ptr #(
  parameter int NUM_BLOCKS = 32,
  parameter int IDX_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             clear_cnt,
  input  logic             inc,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             last
);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_wrap;

  // Block 0 is the NULL block, so wrapping lands on 1, never 0.
  assign idx_wrap = (idx == IDX_W'(NUM_BLOCKS - 1)) ? IDX_W'(1) : idx + IDX_W'(1);

  always_comb begin
    idx_nxt = idx;
    if (restart)  idx_nxt = IDX_W'(1);
    else if (inc) idx_nxt = idx_wrap;
  end

  // cnt = candidates already rejected in this scan; the scan has
  // NUM_BLOCKS-1 candidates, so the last one is seen at NUM_BLOCKS-2.
  assign last = (cnt == IDX_W'(NUM_BLOCKS - 2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= IDX_W'(1);
      cnt <= '0;
    end else begin
      idx <= idx_nxt;
      if (clear_cnt) cnt <= '0;
      else if (inc)  cnt <= cnt + IDX_W'(1);
    end
  end

endmodule

// File: rtl/block_allocator.sv
// Allocator/free engine for the card-list RAM; owns the RAM port while busy.
// ALLOC scans block headers for one with the used MSB clear, sets it and
// returns the block base address. FREE clears the used bit of a block.
// Build option: ALLOC_NEXT_FIT_EN -> next-fit scan (start after the last
// allocation); undefined -> first-fit (every scan starts at block 1).
// Ports:
//   clock, reset          clock / asynchronous active-high reset
//   alloc_req, free_req   1-cycle request pulses, sampled only in IDLE
//   free_addr             base address of the block to free
//   busy, done            operation in flight / 1-cycle completion pulse
//   alloc_ok, err         result flags, valid with done
//   out_address           last allocated base address
//   ram_address/data/wren registered RAM port; ram_q read data (2-cycle read)
//   fsm_state             current FSM state for debug/observation
// Handshake: a request is accepted when it is seen in IDLE; busy rises the
// next cycle and stays high through the done pulse; requests arriving while
// busy are dropped. FREE wins when both requests arrive together.
module block_allocator
  import alloc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_req,
  input  logic              free_req,
  input  logic [ADDR_W-1:0] free_addr,
  output logic              busy,
  output logic              done,
  output logic              alloc_ok,
  output logic              err,
  output logic [ADDR_W-1:0] out_address,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output state_t            fsm_state
);

  localparam int NUM_BLOCKS = (2 ** ADDR_W) / BLOCK_WORDS;
  localparam int IDX_W      = $clog2(NUM_BLOCKS);
  localparam int USED_BIT   = int'(hdr_used_bit(DATA_W));
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);
  localparam logic [DATA_W-1:0] HDR_SET  = DATA_W'(1) << USED_BIT;
`ifdef ALLOC_NEXT_FIT_EN
  localparam bit NEXT_FIT = 1'b1;
`else
  localparam bit NEXT_FIT = 1'b0;
`endif

  state_t           state, state_nxt;
  logic             is_free;
  logic             bad_free;
  logic             free_bad_now;
  logic             ptr_restart, ptr_clear, ptr_inc, ptr_last;
  logic [IDX_W-1:0] ptr_nxt;
  logic [ADDR_W-1:0] cand_base;
  logic             unused_q;

  assign fsm_state    = state;
  assign unused_q     = ^ram_q[USED_BIT-1:0];
  assign free_bad_now = (free_addr == ADDR_W'(NULL_ADDR)) || ((free_addr & OFF_MASK) != '0);
  assign cand_base    = ADDR_W'(block_base(32'(ptr_nxt), BLOCK_WORDS));

  alloc_block_ptr #(.NUM_BLOCKS(NUM_BLOCKS), .IDX_W(IDX_W)) u_ptr (
    .clock     (clock),
    .reset     (reset),
    .restart   (ptr_restart),
    .clear_cnt (ptr_clear),
    .inc       (ptr_inc),
    .idx_nxt   (ptr_nxt),
    .last      (ptr_last)
  );

  always_comb begin
    state_nxt   = state;
    ptr_restart = 1'b0;
    ptr_clear   = 1'b0;
    ptr_inc     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (free_req) begin
          state_nxt = ST_WRITE;
        end else if (alloc_req) begin
          state_nxt   = ST_ISSUE;
          ptr_clear   = 1'b1;
          ptr_restart = !NEXT_FIT;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!ram_q[USED_BIT]) begin
          state_nxt = ST_WRITE;
        end else begin
          // Advance even on the final candidate: in next-fit this returns
          // the pointer to where the failed scan began.
          ptr_inc   = 1'b1;
          state_nxt = ptr_last ? ST_DONE : ST_ISSUE;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_DONE;
        ptr_inc   = NEXT_FIT && !is_free;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // RAM-port and status registers are loaded on the edge that enters the
  // state they belong to, so the read address is on the port for the whole
  // ISSUE/WAIT window and write enable covers exactly the WRITE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      is_free     <= 1'b0;
      bad_free    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      alloc_ok    <= 1'b0;
      err         <= 1'b0;
      out_address <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_DONE);
      alloc_ok <= 1'b0;
      err      <= 1'b0;
      ram_wren <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (free_req) begin
            is_free     <= 1'b1;
            bad_free    <= free_bad_now;
            ram_address <= free_addr;
            ram_data    <= '0;
            ram_wren    <= !free_bad_now;
          end else if (alloc_req) begin
            is_free     <= 1'b0;
            bad_free    <= 1'b0;
            ram_address <= cand_base;
          end
        end
        ST_CHECK: begin
          if (!ram_q[USED_BIT]) begin
            ram_data <= HDR_SET;
            ram_wren <= 1'b1;
          end else if (!ptr_last) begin
            ram_address <= cand_base;
          end
        end
        ST_WRITE: begin
          // Results are published only once the header write has completed,
          // so a reset during WRITE leaves nothing reported as allocated.
          if (!is_free) out_address <= ram_address;
          alloc_ok <= !is_free;
          err      <= is_free && bad_free;
        end
        default: ;
      endcase
    end
  end

endmodule
